// File: rtl/viterbi_ctrl_pkg.sv
// Shared types and constants for the Viterbi frame controller.
package viterbi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } ctrl_state_t;

  // A payload byte carries four rate-1/2 symbol pairs.
  localparam int PAIRS_PER_BYTE = 4;

  // Reserved bits between the overrun flag and the frame count in the status byte.
  localparam logic [2:0] STATUS_PAD = 3'b000;

  // Move the cnt most recent packer bits to the top of the byte and zero the rest.
  function automatic logic [7:0] pad_byte(input logic [7:0] sr, input logic [2:0] cnt);
    logic [3:0] sh;
    sh = 4'd8 - {1'b0, cnt};
    return sr << sh;
  endfunction

endpackage

// File: rtl/viterbi_frame_ctrl_byte_fifo.sv
// First-word-fall-through byte FIFO used as the output buffer to the UART TX.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array write.
  // NOTE: the array has no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Viterbi frame controller: parses a length-prefixed frame from the UART RX,
// feeds symbol pairs to the decoder, flushes it, repacks decoded bits into
// bytes and queues them for the UART TX.
// Build option: define VITERBI_STATUS_BYTE_EN to append a status byte
// {overrun, 3'b000, frame_cnt[3:0]} after every frame.
module viterbi_frame_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter int OBUF_DEPTH = 4,
  parameter int MAX_LEN    = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [1:0] sym_data,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       dec_flush,
  input  logic       dec_bit,
  input  logic       dec_valid,
  output logic       dec_ready,
  input  logic       dec_done,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overrun
);

  ctrl_state_t state, state_nxt;

  logic [7:0] len_cnt, hold_reg;
  logic       hold_full;
  logic [1:0] pair_cnt;
  logic [7:0] pk_sr;
  logic [2:0] pk_cnt;
  logic       done_seen;

  logic       len_ok, sym_fire, last_pair, bit_fire, byte_done, drain_active;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty, can_push, pad_push;
  logic       status_push;
  logic [7:0] fifo_din;

`ifdef VITERBI_STATUS_BYTE_EN
  logic [3:0] frame_cnt;
`endif

  assign len_ok    = (rx_data != 8'd0) && (int'(rx_data) <= MAX_LEN);
  assign sym_valid = (state == FEED) && hold_full;
  assign sym_data  = sym_valid ? hold_reg[7:6] : 2'b00;
  assign sym_fire  = sym_valid && sym_ready;
  assign last_pair = sym_fire && (pair_cnt == 2'(PAIRS_PER_BYTE - 1));
  assign dec_flush = (state == FLUSH);
  assign dec_ready = (state != IDLE) && !fifo_full;
  assign bit_fire  = dec_valid && dec_ready;
  assign byte_done = bit_fire && (pk_cnt == 3'd7);
  assign busy      = (state != IDLE);
  assign tx_valid  = !fifo_empty;
  assign fifo_pop  = !fifo_empty && tx_ready;
  assign can_push  = !fifo_full || fifo_pop;

  // Trailing pushes only start once the decoder has signalled the end of the frame
  // and no decoded bit is landing in the packer in the same cycle.
  assign drain_active = (state == DRAIN) && done_seen && !bit_fire;
  assign pad_push     = drain_active && (pk_cnt != 3'd0) && can_push;
`ifdef VITERBI_STATUS_BYTE_EN
  assign status_push  = drain_active && (pk_cnt == 3'd0) && can_push;
`else
  assign status_push  = 1'b0;
`endif
  assign fifo_push    = byte_done || pad_push || status_push;

  // Select which byte enters the output FIFO this cycle.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    fifo_din = pad_byte(pk_sr, pk_cnt);
    if (byte_done) begin
      fifo_din = {pk_sr[6:0], dec_bit};
    end
`ifdef VITERBI_STATUS_BYTE_EN
    else if (status_push) begin
      fifo_din = {overrun, STATUS_PAD, frame_cnt + 4'd1};
    end
`endif
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (rx_valid && len_ok) state_nxt = FEED;
      FEED:  if (last_pair && (len_cnt == 8'd1)) state_nxt = FLUSH;
      FLUSH: state_nxt = DRAIN;
`ifdef VITERBI_STATUS_BYTE_EN
      DRAIN: if (status_push) state_nxt = IDLE;
`else
      DRAIN: if (drain_active && (pk_cnt == 3'd0)) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Length counter, holding register unpacking and sticky overrun.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_cnt   <= 8'd0;
      hold_reg  <= 8'd0;
      hold_full <= 1'b0;
      pair_cnt  <= 2'd0;
      overrun   <= 1'b0;
    end else begin
      if (state == IDLE && rx_valid && len_ok) len_cnt <= rx_data;
      if (state == FEED) begin
        if (rx_valid && !hold_full) begin
          hold_reg  <= rx_data;
          hold_full <= 1'b1;
          pair_cnt  <= 2'd0;
        end else if (sym_fire) begin
          hold_reg <= {hold_reg[5:0], 2'b00};
          pair_cnt <= pair_cnt + 2'd1;
          if (last_pair) begin
            hold_full <= 1'b0;
            len_cnt   <= len_cnt - 8'd1;
          end
        end
      end
      if (rx_valid && (((state == IDLE) && !len_ok) || ((state == FEED) && hold_full) ||
                       (state == FLUSH) || (state == DRAIN)))
        overrun <= 1'b1;
    end
  end

  // Decoded-bit packer and end-of-frame tracking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pk_sr     <= 8'd0;
      pk_cnt    <= 3'd0;
      done_seen <= 1'b0;
    end else begin
      if (bit_fire) begin
        pk_sr  <= {pk_sr[6:0], dec_bit};
        pk_cnt <= pk_cnt + 3'd1;
      end else if (pad_push) begin
        pk_sr  <= 8'd0;
        pk_cnt <= 3'd0;
      end
      if (state_nxt == IDLE)
        done_seen <= 1'b0;
      else if (dec_done && (state == FLUSH || state == DRAIN))
        done_seen <= 1'b1;
    end
  end

`ifdef VITERBI_STATUS_BYTE_EN
  // Completed-frame counter, advanced when the status byte is queued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            frame_cnt <= 4'd0;
    else if (status_push) frame_cnt <= frame_cnt + 4'd1;
  end
`endif

  byte_fifo #(.DEPTH(OBUF_DEPTH)) u_obuf (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
